cla_accu: RTL and testbench
===========================

# cla_accu

Frame accumulator downstream of the `cla` carry-lookahead adder. It sums a stream of `COUNT` operands into one `4*WIDTH`-bit total, with a sticky overflow flag. Operands enter on a valid/ready handshake and the total leaves on a second valid/ready handshake. The block is the team's standard consumer of `cla` sum/carry outputs and closes the adder into a sequential datapath.

## Interface
- `WIDTH`, default 8: number of 4-bit adder groups; data width is `DW = 4*WIDTH`.
- `COUNT`, default 4: operands per frame; legal range ≥ 1.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_data`  input  DW  operand, unsigned.
- `in_valid`  input  1  operand present.
- `in_ready`  output  1  block accepts an operand this cycle.
- `out_data`  output  DW  frame total.
- `out_ovf`  output  1  carry-out seen at least once during the frame.
- `out_valid`  output  1  total available.
- `out_ready`  input  1  consumer takes the total.

## Operation
- States: `ACC` and `DONE`.
- Registers: `acc` (DW bits), `ovf` (1 bit), `cnt` (`$clog2(COUNT+1)` bits), `state`.
- Adder connection: one `cla` instance with `a = acc`, `b = in_data`. Its sum `s` and carry `c` are the next-state sources.
- In `ACC`:
  - `in_ready = 1`, `out_valid = 0`.
  - On accept (`in_valid && in_ready`): `acc <= s`, `ovf <= ovf | c`, `cnt <= cnt + 1`.
  - If `cnt == COUNT-1` at accept, go to `DONE`.
  - With no accept, all registers hold.
- In `DONE`:
  - `in_ready = 0`, `out_valid = 1`, `out_data = acc`, `out_ovf = ovf`.
  - `in_valid` is ignored and no operand is consumed.
  - On `out_ready`: `acc <= 0`, `ovf <= 0`, `cnt <= 0`, go to `ACC`.
- `out_data` and `out_ovf` are driven from `acc`/`ovf` in every state. They are only meaningful while `out_valid` is high.
- Arithmetic: unsigned, modulo 2^DW by default. Carry is never propagated into `acc`; it is recorded only in `ovf`.
- `COUNT == 1`: every accepted operand moves the block to `DONE`, and the total equals the operand.
- Reset asserted mid-frame: partial sum is discarded, block returns to empty `ACC`. No output is produced for the aborted frame.

## Timing
- Reset values: `acc = 0`, `ovf = 0`, `cnt = 0`, `state = ACC`.
- Output reset values: `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_ovf = 0`.
- Latency: `out_valid` rises on the clock edge that accepts the `COUNT`th operand, so the total is visible the cycle after that acceptance.
- Throughput: one operand per cycle inside a frame. Minimum frame period is `COUNT + 1` cycles with `out_ready` held high.
- Frame overlap: none. The first operand of the next frame is accepted no earlier than the cycle after the output handshake.
- Handshake: `in_ready` and `out_valid` depend only on `state`, with no combinational path from `in_valid` or `out_ready`.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_ovf` are stable.
- Critical path: `acc` → `cla` → `acc` (single cycle).

## Configuration
- Macro: `CLA_ACCU_SATURATE_EN`.
- Defined: on an accept with `c = 1`, `acc <= {DW{1'b1}}` and `ovf <= 1`. Because operands are unsigned, `acc` then remains all-ones for the rest of the frame.
- Undefined: `acc` wraps modulo 2^DW; `ovf` is still set.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `cla_accu_pkg` holds:
  - the state encoding, `ST_ACC = 1'b0` and `ST_DONE = 1'b1`;
  - the `cnt` width helper function.
- Sub-module: the existing `cla` adder, instantiated once with `.WIDTH(WIDTH)`. No other sub-modules.
- Elaboration check rejects `COUNT < 1`.

## Test plan
All scenarios use `WIDTH=2` (`DW=8`) and `COUNT=4`.
- Reset: assert `rst` mid-clock → immediately `in_ready=1`, `out_valid=0`, `out_data=0x00`, `out_ovf=0`.
- Back-to-back operands 0x01, 0x02, 0x03, 0x04 → `out_valid` rises one cycle after the 4th accept with `out_data=0x0A`, `out_ovf=0`.
- Overflow, operands 0xFF, 0x02, 0x00, 0x00:
  - without `CLA_ACCU_SATURATE_EN` → `out_data=0x01`, `out_ovf=1`;
  - with the macro → `out_data=0xFF`, `out_ovf=1`.
- Backpressure: hold `out_ready=0` for 5 cycles in `DONE` while driving `in_valid=1`, data 0x55 → `in_ready=0`, `out_data` stable, no operand consumed. Then release `out_ready` and send 0x10 ×4 → `out_data=0x40`.
- Bubbles: operands 0x10, 0x20, 0x30, 0x40 with random `in_valid` gaps → `out_data=0xA0`, `out_ovf=0`.
- Reset mid-frame: accept 0x80, 0x80, pulse `rst`, then send 0x01 ×4 → `out_data=0x04`, `out_ovf=0`.

Source files
------------

// File: rtl/cla_accu_pkg.sv
// Shared definitions for the cla_accu frame accumulator: state encoding and
// counter width helper.
package cla_accu_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Width needed to count 0..count inclusive.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/cla_accu_cla.sv
// cla: WIDTH groups of 4-bit carry-lookahead logic with a lookahead group
// carry chain; produces an unsigned sum and the final carry-out.
module cla #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [4*WIDTH-1:0] a,
  input  logic [4*WIDTH-1:0] b,
  output logic [4*WIDTH-1:0] s,
  output logic               c
);

  localparam int unsigned DW = 4 * WIDTH;

  logic [DW-1:0]    g;
  logic [DW-1:0]    p;
  logic [DW-1:0]    cy;
  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] gp;
  logic             carry;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    gp    = '0;
    cy    = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    // Bit carries inside each group are expanded from the group carry-in,
    // so only the group carry is chained.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cy[4*i]   = carry;
      cy[4*i+1] = g[4*i] | (p[4*i] & carry);
      cy[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & carry);
      cy[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                | (p[4*i+2] & p[4*i+1] & g[4*i])
                | (p[4*i+2] & p[4*i+1] & p[4*i] & carry);
      carry     = gg[i] | (gp[i] & carry);
    end
    s = p ^ cy;
    c = carry;
  end

endmodule

// File: rtl/cla_accu.sv
// cla_accu: sums COUNT unsigned operands per frame through one cla adder with
// a sticky carry flag. Define CLA_ACCU_SATURATE_EN to clamp the total on carry.
module cla_accu
  import cla_accu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned    DW   = 4 * WIDTH;
  localparam int unsigned    CW   = cnt_width(COUNT);
  localparam logic [CW-1:0]  LAST = CW'(COUNT - 1);

  if (COUNT < 1) begin : g_bad_count
    $error("cla_accu: COUNT must be >= 1");
  end

  state_t        state, state_n;
  logic [DW-1:0] acc, acc_n;
  logic          ovf, ovf_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] sum;
  logic          carry;

  cla #(.WIDTH(WIDTH)) u_cla (
    .a (acc),
    .b (in_data),
    .s (sum),
    .c (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ovf_n     = ovf;
    cnt_n     = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef CLA_ACCU_SATURATE_EN
          acc_n = carry ? '1 : sum;
`else
          acc_n = sum;
`endif
          ovf_n = ovf | carry;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_ACC;
        end
      end
      default: state_n = ST_ACC;
    endcase
  end

  assign out_data = acc;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_cla_accu.sv
// Randomized self-checking bench for cla_accu (WIDTH=2, COUNT=4) against a
// cycle-level arithmetic model of the frame accumulator.
module tb_cla_accu;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned COUNT = 4;
  localparam int unsigned DW    = 4 * WIDTH;
  localparam int          MAXV  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  // Model state: plain integer arithmetic on the frame contents.
  int m_acc;
  int m_n;
  bit m_ovf;
  bit m_done;

  cla_accu #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_acc  = 0;
    m_n    = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_add(input int op);
    int t;
    t = m_acc + op;
    if (t > MAXV) begin
      m_ovf = 1'b1;
`ifdef CLA_ACCU_SATURATE_EN
      m_acc = MAXV;
`else
      m_acc = t - (MAXV + 1);
`endif
    end else begin
      m_acc = t;
    end
  endfunction

  // One clock: compare outputs at the falling edge, advance the model with the
  // inputs that will be sampled on the next rising edge, then step past it.
  task automatic cycle();
    @(negedge clk);
    check("in_ready", in_ready, !m_done);
    check("out_valid", out_valid, m_done);
    if (m_done) begin
      check("out_data", out_data, m_acc[DW-1:0]);
      check("out_ovf", out_ovf, m_ovf);
    end
    if (m_done) begin
      if (out_ready) model_clear();
    end else if (in_valid) begin
      model_add(int'(in_data));
      m_n++;
      if (m_n == COUNT) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame with random idle gaps; checks the total once visible and
  // then completes the output handshake.
  task automatic run_frame(input logic [DW-1:0] ops[COUNT], input int gap_pct,
                           input logic [DW-1:0] exp_data, input logic exp_ovf,
                           input int hold);
    for (int i = 0; i < COUNT; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        cycle();
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("frame_valid", out_valid, 1'b1);
    check("frame_data", out_data, exp_data);
    check("frame_ovf", out_ovf, exp_ovf);
    for (int k = 0; k < hold; k++) cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  function automatic logic [DW:0] frame_ref(input logic [DW-1:0] ops[COUNT]);
    int  acc;
    bit  ovf;
    acc = 0;
    ovf = 1'b0;
    foreach (ops[i]) begin
      acc += int'(ops[i]);
      if (acc > MAXV) begin
        ovf = 1'b1;
`ifdef CLA_ACCU_SATURATE_EN
        acc = MAXV;
`else
        acc -= MAXV + 1;
`endif
      end
    end
    return {ovf, acc[DW-1:0]};
  endfunction

  initial begin
    logic [DW-1:0] ops[COUNT];
    logic [DW:0]   ref_v;
    logic [DW-1:0] sat_exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    async_reset();

    ops = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(ops, 0, 8'h0A, 1'b0, 0);

`ifdef CLA_ACCU_SATURATE_EN
    sat_exp = 8'hFF;
`else
    sat_exp = 8'h01;
`endif
    ops = '{8'hFF, 8'h02, 8'h00, 8'h00};
    run_frame(ops, 0, sat_exp, 1'b1, 1);

    // Backpressure: operands offered while the total is held are ignored.
    for (int i = 0; i < COUNT; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      cycle();
    end
    out_ready = 1'b0;
    in_data   = 8'h55;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_data_stable", out_data, 8'h44);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    ops = '{8'h10, 8'h10, 8'h10, 8'h10};
    run_frame(ops, 0, 8'h40, 1'b0, 0);

    ops = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_frame(ops, 50, 8'hA0, 1'b0, 2);

    in_valid = 1'b1;
    in_data  = 8'h80;
    cycle();
    cycle();
    in_valid = 1'b0;
    async_reset();
    ops = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_frame(ops, 20, 8'h04, 1'b0, 0);

    for (int f = 0; f < 8; f++) begin
      foreach (ops[i]) ops[i] = DW'($urandom_range(0, MAXV));
      ref_v = frame_ref(ops);
      run_frame(ops, 30, ref_v[DW-1:0], ref_v[DW], int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
